// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Performs a WIDTH-bit addition by running one 4-bit ripple adder over
// NIBBLES successive cycles. The least-significant nibble goes first.
// The carry between nibbles is held in carry_r.
// Handshake: start is sampled only while ready=1. done pulses for one cycle
// when sum/cout are updated.
// Optional feature: define NIBBLE_SERIAL_SUB_EN to add the 'sub' port.
// With sub=1 the block computes a-b: B is inverted and the initial carry is 1.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               carry_r;
  logic [WIDTH-1:0]   work_r;
  logic [IDX_W-1:0]   idx_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ready_r;
  logic               done_r;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic               sub_r;
`endif

  logic [IDX_W+1:0]   nib_base_s;
  logic [3:0]         a_nib_s;
  logic [3:0]         b_nib_s;
  logic [3:0]         add_sum_s;
  logic               add_cout_s;
  logic [WIDTH-1:0]   work_nxt_s;

  // Shared 4-bit ripple adder (R_4bit behaviour): returns {cout, sum}
  function automatic logic [4:0] r_4bit_add(input logic [3:0] x,
                                            input logic [3:0] y,
                                            input logic       ci);
    logic [3:0] s;
    logic       c;
    c = ci;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: one pass per nibble, then a single DONE cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (idx_r == LAST_IDX) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Select the current nibble and run it through the shared adder
  always_comb begin
    nib_base_s = {idx_r, 2'b00};
    a_nib_s    = a_r[nib_base_s +: 4];
`ifdef NIBBLE_SERIAL_SUB_EN
    if (sub_r) begin
      b_nib_s = ~b_r[nib_base_s +: 4];
    end else begin
      b_nib_s = b_r[nib_base_s +: 4];
    end
`else
    b_nib_s    = b_r[nib_base_s +: 4];
`endif
    {add_cout_s, add_sum_s} = r_4bit_add(a_nib_s, b_nib_s, carry_r);
    work_nxt_s = work_r;
    work_nxt_s[nib_base_s +: 4] = add_sum_s;
  end

  // Operand capture, per-nibble accumulation and result update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      work_r  <= {WIDTH{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
      sub_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            work_r <= {WIDTH{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_r  <= sub;
            if (sub) begin
              carry_r <= 1'b1;
            end else begin
              carry_r <= cin;
            end
`else
            carry_r <= cin;
`endif
          end
        end
        S_RUN: begin
          work_r  <= work_nxt_s;
          carry_r <= add_cout_s;
          idx_r   <= idx_r + IDX_ONE;
          if (idx_r == LAST_IDX) begin
            sum_r  <= work_nxt_s;
            cout_r <= add_cout_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered handshake outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (state_nxt_s == S_IDLE);
      done_r  <= (state_nxt_s == S_DONE);
    end
  end

  assign ready = ready_r;
  assign done  = done_r;
  assign sum   = sum_r;
  assign cout  = cout_r;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
// The reference model computes the full-width result arithmetically, and the
// expected timing comes from the nibble count.
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic         sub;
`endif
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef NIBBLE_SERIAL_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Reference: {cout, sum} of a full-width add or subtract
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
    else   return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Drives one request and records what the DUT shows on each following cycle
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic tsub,
                        output logic [W-1:0] osum, output logic ocout,
                        output int odone_cyc, output int odone_cnt,
                        output logic ordy0, output logic ordyn, output logic ordyn1,
                        output logic ostable);
    logic [W-1:0] prev;
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: ready=%b, required 1 within 20 cycles", ready);
    end
    prev = sum; ostable = 1'b1; odone_cyc = -1; odone_cnt = 0;
    osum = sum; ocout = cout; ordyn = 1'bx; ordyn1 = 1'bx;
    a = ta; b = tb_v; cin = tcin; start = 1'b1;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub = tsub;
`endif
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    ordy0 = ready;
    for (int k = 1; k <= N + 3; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        odone_cnt++; odone_cyc = k; osum = sum; ocout = cout;
      end else if (odone_cnt == 0 && sum !== prev) begin
        ostable = 1'b0;
      end
      if (k == N) ordyn = ready;
      if (k == N + 1) ordyn1 = ready;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub = 1'b0;
`endif
    #3 rst_n = 1'b0;
    #1;
    checks += 4;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", ready); end
    if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h, required 0000", sum); end
    if (cout !== 1'b0)  begin errors++; $display("FAIL reset_cout: got %b, required 0", cout); end
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks += 4;
    if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b, required 1", ready); end
    if (done !== 1'b0)  begin errors++; $display("FAIL post_reset_done: got %b, required 0", done); end
    if (sum !== 16'h0000) begin errors++; $display("FAIL post_reset_sum: got %h, required 0000", sum); end
    if (cout !== 1'b0)  begin errors++; $display("FAIL post_reset_cout: got %b, required 0", cout); end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'h0FFF};
    logic [W-1:0] vb [3] = '{16'h4321, 16'h0001, 16'h0000};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] rs; logic rc, r0, rn, rn1, st; int dc, dn;
    logic [W:0] exp_v;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, rs, rc, dc, dn, r0, rn, rn1, st);
      exp_v = model(va[i], vb[i], vc[i], 1'b0);
      checks += 8;
      if (rs !== exp_v[W-1:0]) begin errors++; $display("FAIL dir_sum[%0d]: got %h, required %h", i, rs, exp_v[W-1:0]); end
      if (rc !== exp_v[W])     begin errors++; $display("FAIL dir_cout[%0d]: got %b, required %b", i, rc, exp_v[W]); end
      if (dc != N)             begin errors++; $display("FAIL dir_done_edge[%0d]: got %0d, required %0d", i, dc, N); end
      if (dn != 1)             begin errors++; $display("FAIL dir_done_count[%0d]: got %0d, required 1", i, dn); end
      if (r0 !== 1'b0)         begin errors++; $display("FAIL dir_ready_edge0[%0d]: got %b, required 0", i, r0); end
      if (rn !== 1'b0)         begin errors++; $display("FAIL dir_ready_in_done[%0d]: got %b, required 0", i, rn); end
      if (rn1 !== 1'b1)        begin errors++; $display("FAIL dir_ready_after[%0d]: got %b, required 1", i, rn1); end
      if (st !== 1'b1)         begin errors++; $display("FAIL dir_sum_stable[%0d]: partial result visible", i); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, rs; logic rcin, rsub, rc, r0, rn, rn1, st; int dc, dn;
    logic [W:0] exp_v;
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rcin = 1'($urandom);
      if (i % 5 == 0) rb = ~ra;  // forces long carry chains
`ifdef NIBBLE_SERIAL_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      run_op(ra, rb, rcin, rsub, rs, rc, dc, dn, r0, rn, rn1, st);
      exp_v = model(ra, rb, rcin, rsub);
      checks += 4;
      if (rs !== exp_v[W-1:0] || rc !== exp_v[W]) begin
        errors++;
        $display("FAIL rnd_result[%0d]: a=%h b=%h cin=%b sub=%b got %b_%h, required %b_%h",
                 i, ra, rb, rcin, rsub, rc, rs, exp_v[W], exp_v[W-1:0]);
      end
      if (dc != N || dn != 1) begin errors++; $display("FAIL rnd_done[%0d]: edge=%0d count=%0d, required edge %0d count 1", i, dc, dn, N); end
      if (r0 !== 1'b0 || rn !== 1'b0 || rn1 !== 1'b1) begin errors++; $display("FAIL rnd_ready[%0d]: got %b%b%b, required 001", i, r0, rn, rn1); end
      if (st !== 1'b1) begin errors++; $display("FAIL rnd_sum_stable[%0d]: partial result visible", i); end
    end
  endtask

  task automatic test_ignore_start();
    int dc; logic [W-1:0] rs;
    dc = 0; rs = '0;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub = 1'b0;
`endif
    @(posedge clk); #1;  // edge 0: accepted
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2 || k == 5) begin
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin dc++; rs = sum; end
    end
    start = 1'b0;
    checks += 3;
    if (dc != 1)         begin errors++; $display("FAIL ign_done_count: got %0d, required 1", dc); end
    if (rs !== 16'h3333) begin errors++; $display("FAIL ign_sum: got %h, required 3333", rs); end
    if (ready !== 1'b1)  begin errors++; $display("FAIL ign_ready: got %b, required 1", ready); end

    // Continuous start: one accept every N+2 cycles
    dc = 0;
    a = 16'h0101; b = 16'h0202; cin = 1'b0; start = 1'b1;
    for (int e = 0; e < 24; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        checks++;
        if (e != N + dc * (N + 2)) begin
          errors++; $display("FAIL cont_done_edge[%0d]: got %0d, required %0d", dc, e, N + dc * (N + 2));
        end
        checks++;
        if (sum !== 16'h0303) begin errors++; $display("FAIL cont_sum[%0d]: got %h, required 0303", dc, sum); end
        dc++;
      end
    end
    start = 1'b0;
    checks++;
    if (dc != 4) begin errors++; $display("FAIL cont_done_count: got %0d, required 4", dc); end
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int dc; logic [W-1:0] rs; logic rc, r0, rn, rn1, st; int dcy, dn;
    dc = 0;
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub = 1'b0;
`endif
    @(posedge clk); #1; start = 1'b0;  // edge 0
    @(posedge clk); #1;
    @(posedge clk); #1;                // after edge 2
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b, required 1", ready); end
    if (done !== 1'b0)  begin errors++; $display("FAIL abort_done: got %b, required 0", done); end
    if (sum !== 16'h0000) begin errors++; $display("FAIL abort_sum: got %h, required 0000", sum); end
    if (cout !== 1'b0)  begin errors++; $display("FAIL abort_cout: got %b, required 0", cout); end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dc++;
    end
    checks += 2;
    if (dc != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses, required 0", dc); end
    if (sum !== 16'h0000) begin errors++; $display("FAIL abort_sum_hold: got %h, required 0000", sum); end
    run_op(16'h0002, 16'h0003, 1'b0, 1'b0, rs, rc, dcy, dn, r0, rn, rn1, st);
    checks += 2;
    if (rs !== 16'h0005 || rc !== 1'b0) begin errors++; $display("FAIL abort_next_op: got %b_%h, required 0_0005", rc, rs); end
    if (dcy != N) begin errors++; $display("FAIL abort_next_done: got edge %0d, required %0d", dcy, N); end
  endtask

`ifdef NIBBLE_SERIAL_SUB_EN
  task automatic test_sub();
    logic [W-1:0] rs; logic rc, r0, rn, rn1, st; int dcy, dn;
    run_op(16'h0005, 16'h0007, 1'($urandom), 1'b1, rs, rc, dcy, dn, r0, rn, rn1, st);
    checks++;
    if (rs !== 16'hFFFE || rc !== 1'b0) begin errors++; $display("FAIL sub_borrow: got %b_%h, required 0_fffe", rc, rs); end
    run_op(16'h0007, 16'h0005, 1'($urandom), 1'b1, rs, rc, dcy, dn, r0, rn, rn1, st);
    checks++;
    if (rs !== 16'h0002 || rc !== 1'b1) begin errors++; $display("FAIL sub_noborrow: got %b_%h, required 1_0002", rc, rs); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
`ifdef NIBBLE_SERIAL_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencing controller that performs a WIDTH-bit addition by reusing one instance of the team's 4-bit ripple adder (R_4bit: a, b, cin -> sum, cout) over successive clock cycles, processing the least-significant nibble first.
- Trades latency for area. Serves as the shared arithmetic engine for wider datapaths that cannot afford a full-width adder.
- Uses a start/ready/done handshake toward the requesting logic.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of 4 and at least 4; any other value is a compile-time error.
- NIBBLES, WIDTH/4, derived localparam and not overridable. It is the number of adder passes.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only when ready=1.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse; sum/cout valid from this cycle.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=1, done=0, sum=0, cout=0. Internal operand regs, carry reg, work reg and nibble index are cleared.
- Reset mid-operation aborts the operation. No done pulse is generated and the outputs return to their reset values.
- States:
  - IDLE: ready=1. If start=1 at an edge, latch a, b, cin into the carry reg, set idx=0, and go to RUN. Otherwise stay in IDLE.
  - RUN: ready=0. Each cycle, drive R_4bit with a_reg[4*idx+:4], b_reg[4*idx+:4] and carry reg. At the edge, write the adder sum into work[4*idx+:4], load carry reg with the adder cout, and increment idx. When idx==NIBBLES-1 at the edge, load sum<=final work value, load cout<=adder cout, and go to DONE.
  - DONE: done=1 and ready=0 for exactly one cycle, then unconditionally go to IDLE.
- Timing, with edge 0 as the edge that samples start:
  - nibbles are written on edges 1..NIBBLES;
  - done is high between edge NIBBLES and edge NIBBLES+1;
  - ready returns high after edge NIBBLES+1.
  - Minimum start-to-start period is NIBBLES+2 cycles.
- start is ignored while ready=0, including during DONE. Operand changes during RUN have no effect because they were captured at accept.
- sum and cout hold their value from the last completed operation until the next operation completes. They never show partial results.
- done and ready are registered outputs. There is no combinational path from start, a or b to any output.
- Arithmetic is modulo 2^WIDTH. The carry chain crosses nibble boundaries only through the carry reg, one nibble per cycle.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_EN.
- Defined: adds input port sub (1 bit), captured on accept. When sub=1, B nibbles are inverted before the adder and the initial carry is forced to 1, with cin ignored. The result is a-b mod 2^WIDTH, and cout=1 means no borrow. When sub=0, behaviour is identical to the undefined case.
- Undefined: the sub port does not exist and the block is add-only.

Test Plan:
- Assert rst_n=0 asynchronously mid-cycle -> ready=1, done=0, sum=16'h0000, cout=0 immediately. These values hold after release.
- a=16'h1234, b=16'h4321, cin=0, 1-cycle start -> ready falls after edge 0; done high only between edges 4 and 5; sum=16'h5555, cout=0; ready=1 after edge 5.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1 (carry ripples through all 4 passes). Then a=16'h0FFF, b=16'h0000, cin=1 -> sum=16'h1000, cout=0.
- Start 16'h1111+16'h2222, then assert start again with a=16'hFFFF, b=16'hFFFF on edges 2 and 5 (RUN and DONE) -> second request ignored; sum=16'h3333, exactly one done pulse. Holding start high continuously gives one accept every 6 cycles.
- Start 16'h00FF+16'h0001, then pull rst_n low after edge 2 -> no done pulse; sum=0, cout=0, ready=1. A following 16'h0002+16'h0003 yields 16'h0005.
- With NIBBLE_SERIAL_SUB_EN: a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0. a=16'h0007, b=16'h0005, sub=1 -> sum=16'h0002, cout=1. The cin value is irrelevant in both cases.
